// File: rtl/rice_pkg.sv
// Shared types and helpers for the FLAC Rice partition decoder.
// States, escape-width constant, escape code derivation and zigzag unfold.
package rice_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ESC_W,
        ST_UNARY,
        ST_BINARY,
        ST_RAW,
        ST_ZERO
    } state_e;

    localparam int ESC_WIDTH_BITS = 5;
    localparam int Q_W            = 16;             // quotient / oMSB width
    localparam int SH_W           = 32;             // holds up to 31 remainder or raw bits
    localparam int U_W            = Q_W + SH_W;     // unfolded codeword width

    // All-ones Rice parameter marks an escaped (raw-width) partition.
    function automatic logic [SH_W-1:0] esc_code(input int param_w);
        return SH_W'((64'd1 << param_w) - 64'd1);
    endfunction

    // Zigzag unfold: even u -> u/2, odd u -> -(u/2)-1, kept to data_w bits.
    function automatic logic [U_W-1:0] zigzag_fold(input logic [U_W-1:0] u, input int data_w);
        logic [U_W-1:0] v;
        v = u[0] ? ~(u >> 1) : (u >> 1);
        return v & ((U_W'(1) << data_w) - U_W'(1));
    endfunction

endpackage

// File: rtl/rice_unfold.sv
// Combinational Rice codeword unfold: (q << k) | r, then zigzag to a signed residual.
module rice_unfold
    import rice_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int PARAM_W = 4
) (
    input  logic [Q_W-1:0]     q_i,
    input  logic [SH_W-1:0]    r_i,
    input  logic [PARAM_W-1:0] k_i,
    output logic [DATA_W-1:0]  res_o
);

    logic [U_W-1:0] u;
    logic [U_W-1:0] f;

    always_comb begin
        u     = (U_W'(q_i) << k_i) | U_W'(r_i);
        f     = zigzag_fold(u, DATA_W);
        res_o = f[DATA_W-1:0];
    end

endmodule

// File: rtl/rice_partition_decoder.sv
// Serial Rice residual decoder for one FLAC partition, one stream bit per qualified cycle.
// Define RICE_ESCAPE_EN to enable escape (raw-width) partitions.
module rice_partition_decoder
    import rice_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int PARAM_W = 4,
    parameter int MAX_MSB = 255,
    parameter int COUNT_W = 16
) (
    input  logic               iClock,
    input  logic               iReset,
    input  logic               iEnable,
    input  logic               iStart,
    input  logic [PARAM_W-1:0] iRiceParam,
    input  logic [COUNT_W-1:0] iCount,
    input  logic               iValid,
    input  logic               iData,
    output logic               oReady,
    output logic [DATA_W-1:0]  oResidual,
    output logic               oResidValid,
    output logic [15:0]        oMSB,
    output logic [15:0]        oLSB,
    output logic               oDone,
    output logic               oError
);

`ifdef RICE_ESCAPE_EN
    localparam logic [PARAM_W-1:0] ESC_K = PARAM_W'(esc_code(PARAM_W));
`endif

    state_e             state_q, state_d;
    logic [PARAM_W-1:0] k_q, k_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [Q_W-1:0]     q_q, q_d;
    logic [SH_W-1:0]    sh_q, sh_d;
    logic [4:0]         bcnt_q, bcnt_d;
    logic [DATA_W-1:0]  res_q, res_d;
    logic [15:0]        msb_q, msb_d, lsb_q, lsb_d;
    logic               rv_q, rv_d, done_q, done_d, err_q, err_d;
`ifdef RICE_ESCAPE_EN
    logic [ESC_WIDTH_BITS-1:0] n_q, n_d;
    logic [5:0]                raw_sh;
    logic [SH_W-1:0]           raw_tmp, raw_sx;
`endif

    logic              rdy, take, emit;
    logic [SH_W-1:0]   sh_in, rice_r;
    logic [DATA_W-1:0] rice_res, emit_res;
    logic [15:0]       emit_msb, emit_lsb;

    assign rdy    = (state_q == ST_UNARY) || (state_q == ST_BINARY) ||
                    (state_q == ST_ESC_W) || (state_q == ST_RAW);
    assign take   = rdy & iValid;
    assign sh_in  = {sh_q[SH_W-2:0], iData};
    assign rice_r = (state_q == ST_BINARY) ? sh_in : '0;

    rice_unfold #(.DATA_W(DATA_W), .PARAM_W(PARAM_W)) u_unfold (
        .q_i   (q_q),
        .r_i   (rice_r),
        .k_i   (k_q),
        .res_o (rice_res)
    );

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        q_d      = q_q;
        sh_d     = sh_q;
        bcnt_d   = bcnt_q;
        res_d    = res_q;
        msb_d    = msb_q;
        lsb_d    = lsb_q;
        rv_d     = rv_q;
        done_d   = done_q;
        err_d    = err_q;
        emit     = 1'b0;
        emit_res = '0;
        emit_msb = '0;
        emit_lsb = '0;
`ifdef RICE_ESCAPE_EN
        n_d      = n_q;
        raw_sh   = 6'd32 - {1'b0, n_q};
        raw_tmp  = sh_in << raw_sh;
        raw_sx   = $unsigned($signed(raw_tmp) >>> raw_sh);
`endif
        // Disabled cycles hold every register, so strobes wait for the next enabled cycle.
        if (iEnable) begin
            rv_d   = 1'b0;
            done_d = 1'b0;
            if (iStart) begin
                k_d    = iRiceParam;
                cnt_d  = iCount;
                q_d    = '0;
                sh_d   = '0;
                bcnt_d = '0;
                err_d  = 1'b0;
`ifdef RICE_ESCAPE_EN
                n_d    = '0;
`endif
                if (iCount == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
`ifdef RICE_ESCAPE_EN
                else if (iRiceParam == ESC_K) state_d = ST_ESC_W;
`endif
                else state_d = ST_UNARY;
            end else if (take) begin
                case (state_q)
                    ST_UNARY: begin
                        if (!iData) begin
                            if (q_q == Q_W'(MAX_MSB)) begin
                                err_d   = 1'b1;
                                state_d = ST_IDLE;
                            end else begin
                                q_d = q_q + Q_W'(1);
                            end
                        end else if (k_q == '0) begin
                            emit     = 1'b1;
                            emit_res = rice_res;
                            emit_msb = q_q;
                        end else begin
                            state_d = ST_BINARY;
                        end
                    end
                    ST_BINARY: begin
                        sh_d   = sh_in;
                        bcnt_d = bcnt_q + 5'd1;
                        if (bcnt_q == 5'(k_q) - 5'd1) begin
                            emit     = 1'b1;
                            emit_res = rice_res;
                            emit_msb = q_q;
                            emit_lsb = sh_in[15:0];
                        end
                    end
`ifdef RICE_ESCAPE_EN
                    ST_ESC_W: begin
                        sh_d   = sh_in;
                        bcnt_d = bcnt_q + 5'd1;
                        if (bcnt_q == 5'(ESC_WIDTH_BITS - 1)) begin
                            n_d     = sh_in[ESC_WIDTH_BITS-1:0];
                            sh_d    = '0;
                            bcnt_d  = '0;
                            state_d = (sh_in[ESC_WIDTH_BITS-1:0] == '0) ? ST_ZERO : ST_RAW;
                        end
                    end
                    ST_RAW: begin
                        sh_d   = sh_in;
                        bcnt_d = bcnt_q + 5'd1;
                        if (bcnt_q == n_q - 5'd1) begin
                            emit     = 1'b1;
                            emit_res = DATA_W'($signed(raw_sx));
                            emit_lsb = sh_in[15:0];
                        end
                    end
`endif
                    default: ;
                endcase
            end
`ifdef RICE_ESCAPE_EN
            else if (state_q == ST_ZERO) begin
                emit = 1'b1;
            end
`endif
            if (emit) begin
                res_d  = emit_res;
                msb_d  = emit_msb;
                lsb_d  = emit_lsb;
                rv_d   = 1'b1;
                q_d    = '0;
                sh_d   = '0;
                bcnt_d = '0;
                cnt_d  = cnt_q - COUNT_W'(1);
                if (cnt_q == COUNT_W'(1)) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (state_q == ST_BINARY) begin
                    state_d = ST_UNARY;
                end
            end
        end
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            sh_q    <= '0;
            bcnt_q  <= '0;
            res_q   <= '0;
            msb_q   <= '0;
            lsb_q   <= '0;
            rv_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef RICE_ESCAPE_EN
            n_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            sh_q    <= sh_d;
            bcnt_q  <= bcnt_d;
            res_q   <= res_d;
            msb_q   <= msb_d;
            lsb_q   <= lsb_d;
            rv_q    <= rv_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef RICE_ESCAPE_EN
            n_q     <= n_d;
`endif
        end
    end

    assign oReady      = rdy;
    assign oResidual   = res_q;
    assign oResidValid = rv_q & iEnable;
    assign oMSB        = msb_q;
    assign oLSB        = lsb_q;
    assign oDone       = done_q & iEnable;
    assign oError      = err_q;

endmodule

// File: tb/tb_rice_partition_decoder.sv
// Self-checking bench: table-driven partitions through a scoreboard plus hand-written corner sequences.
module tb_rice_partition_decoder;
    localparam int DATA_W = 16, PARAM_W = 4, COUNT_W = 16;

    logic iClock = 1'b0, iReset = 1'b0, iEnable = 1'b1, iStart = 1'b0, iValid = 1'b0, iData = 1'b0;
    logic [PARAM_W-1:0] iRiceParam = '0;
    logic [COUNT_W-1:0] iCount = '0;

    logic oReady, oResidValid, oDone, oError;
    logic [DATA_W-1:0] oResidual;
    logic [15:0] oMSB, oLSB;
    logic o_oReady, o_oResidValid, o_oDone, o_oError;
    logic [DATA_W-1:0] o_oResidual;
    logic [15:0] o_oMSB, o_oLSB;

    rice_partition_decoder #(.DATA_W(DATA_W), .PARAM_W(PARAM_W), .MAX_MSB(255), .COUNT_W(COUNT_W)) dut (
        .iClock(iClock), .iReset(iReset), .iEnable(iEnable), .iStart(iStart),
        .iRiceParam(iRiceParam), .iCount(iCount), .iValid(iValid), .iData(iData),
        .oReady(oReady), .oResidual(oResidual), .oResidValid(oResidValid),
        .oMSB(oMSB), .oLSB(oLSB), .oDone(oDone), .oError(oError));

    // Second instance with a tiny quotient limit for the overflow case.
    rice_partition_decoder #(.DATA_W(DATA_W), .PARAM_W(PARAM_W), .MAX_MSB(4), .COUNT_W(COUNT_W)) dut_o (
        .iClock(iClock), .iReset(iReset), .iEnable(iEnable), .iStart(iStart),
        .iRiceParam(iRiceParam), .iCount(iCount), .iValid(iValid), .iData(iData),
        .oReady(o_oReady), .oResidual(o_oResidual), .oResidValid(o_oResidValid),
        .oMSB(o_oMSB), .oLSB(o_oLSB), .oDone(o_oDone), .oError(o_oError));

    always #5 iClock = ~iClock;

    typedef struct {
        logic [15:0] res, msb, lsb;
        logic        done;
    } exp_t;

    typedef struct {
        logic [PARAM_W-1:0] k;
        logic [COUNT_W-1:0] cnt;
        int                 nb;
        logic [63:0]        bits;
        int                 ne;
        logic [3:0][15:0]   res, msb, lsb;
    } vec_t;

    exp_t sb[$];
    vec_t vt[5];
    int total = 0, bad = 0, dones = 0, o_dones = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every strobe pops one expected residual.
    initial forever begin
        exp_t e;
        @(negedge iClock);
        if (oDone) dones++;
        if (o_oDone) o_dones++;
        if (oResidValid) begin
            if (sb.size() == 0) chk("unexpected_strobe", 32'(sb.size()), 32'd1);
            else begin
                e = sb.pop_front();
                chk("residual", 32'(oResidual), 32'(e.res));
                chk("msb", 32'(oMSB), 32'(e.msb));
                chk("lsb", 32'(oLSB), 32'(e.lsb));
                chk("done_with_strobe", 32'(oDone), 32'(e.done));
            end
        end
    end

    task automatic start(input logic [PARAM_W-1:0] k, input logic [COUNT_W-1:0] c);
        iStart = 1'b1; iRiceParam = k; iCount = c; iValid = 1'b0;
        @(posedge iClock); #1;
        iStart = 1'b0;
    endtask

    task automatic send(input logic b);
        iValid = 1'b1; iData = b;
        @(posedge iClock); #1;
        iValid = 1'b0;
    endtask

    task automatic push(input logic [15:0] r, input logic [15:0] m, input logic [15:0] l, input logic d);
        exp_t x;
        x.res = r; x.msb = m; x.lsb = l; x.done = d;
        sb.push_back(x);
    endtask

    task automatic drain(input string name, input int d0);
        for (int c = 0; c < 80 && sb.size() != 0; c++) @(posedge iClock);
        repeat (3) @(posedge iClock);
        #1;
        chk({name, "_drained"}, 32'(sb.size()), 32'd0);
        chk({name, "_done_count"}, 32'(dones - d0), 32'd1);
        sb.delete();
    endtask

    task automatic run_vec(input vec_t v, input bit gaps, input string name);
        int d0;
        d0 = dones;
        start(v.k, v.cnt);
        for (int e = 0; e < v.ne; e++) push(v.res[e], v.msb[e], v.lsb[e], e == v.ne - 1);
        for (int i = v.nb - 1; i >= 0; i--) begin
            send(v.bits[i]);
            if (gaps && (i % 2 == 0)) begin
                iEnable = 1'b0; iValid = 1'b1; iData = ~v.bits[i];
                repeat (2) @(posedge iClock);
                #1;
                iEnable = 1'b1; iValid = 1'b0;
            end
            if (gaps && (i % 3 == 0)) begin
                iData = ~v.bits[i];
                @(posedge iClock); #1;
            end
        end
        drain(name, d0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int d0, od0;
        vt[0] = '{k: 4'd3, cnt: 16'd3, nb: 19, bits: 64'b0000011010011101010, ne: 3,
                  res: {16'd0, 16'd1, 16'd11, 16'hFFE9}, msb: {16'd0, 16'd0, 16'd2, 16'd5},
                  lsb: {16'd0, 16'd2, 16'd6, 16'd5}};
        vt[1] = '{k: 4'd0, cnt: 16'd2, nb: 5, bits: 64'b00011, ne: 2,
                  res: {16'd0, 16'd0, 16'd0, 16'hFFFE}, msb: {16'd0, 16'd0, 16'd0, 16'd3},
                  lsb: {16'd0, 16'd0, 16'd0, 16'd0}};
        vt[2] = '{k: 4'd1, cnt: 16'd2, nb: 6, bits: 64'b110010, ne: 2,
                  res: {16'd0, 16'd0, 16'd2, 16'hFFFF}, msb: {16'd0, 16'd0, 16'd2, 16'd0},
                  lsb: {16'd0, 16'd0, 16'd0, 16'd1}};
        vt[3] = '{k: 4'd14, cnt: 16'd1, nb: 18, bits: 64'b000100000000000001, ne: 1,
                  res: {16'd0, 16'd0, 16'd0, 16'h9FFF}, msb: {16'd0, 16'd0, 16'd0, 16'd3},
                  lsb: {16'd0, 16'd0, 16'd0, 16'd1}};
`ifdef RICE_ESCAPE_EN
        vt[4] = '{k: 4'd15, cnt: 16'd3, nb: 17, bits: 64'b00100111101111000, ne: 3,
                  res: {16'd0, 16'hFFF8, 16'd7, 16'hFFFF}, msb: {16'd0, 16'd0, 16'd0, 16'd0},
                  lsb: {16'd0, 16'd8, 16'd7, 16'd15}};
`else
        vt[4] = '{k: 4'd15, cnt: 16'd1, nb: 16, bits: 64'b1000000000000101, ne: 1,
                  res: {16'd0, 16'd0, 16'd0, 16'hFFFD}, msb: {16'd0, 16'd0, 16'd0, 16'd0},
                  lsb: {16'd0, 16'd0, 16'd0, 16'd5}};
`endif

        // Reset state
        repeat (2) @(negedge iClock);
        chk("rst_ready", 32'(oReady), 0);
        chk("rst_valid", 32'(oResidValid), 0);
        chk("rst_done", 32'(oDone), 0);
        chk("rst_error", 32'(oError), 0);
        chk("rst_residual", 32'(oResidual), 0);
        chk("rst_msb", 32'(oMSB), 0);
        chk("rst_lsb", 32'(oLSB), 0);
        @(posedge iClock); #1;
        iReset = 1'b1;
        @(posedge iClock); #1;

        for (int v = 0; v < 5; v++) run_vec(vt[v], 1'b0, $sformatf("vec%0d", v));
        run_vec(vt[0], 1'b1, "gapped_vec0");

        // k=0: each strobe one cycle after its stop bit, back to back
        d0 = dones;
        start(4'd0, 16'd2);
        push(16'hFFFE, 16'd3, 16'd0, 1'b0);
        push(16'd0, 16'd0, 16'd0, 1'b1);
        send(1'b0); send(1'b0); send(1'b0); send(1'b1);
        @(negedge iClock);
        chk("k0_lat1_valid", 32'(oResidValid), 1);
        send(1'b1);
        @(negedge iClock);
        chk("k0_lat2_valid", 32'(oResidValid), 1);
        chk("k0_lat2_done", 32'(oDone), 1);
        drain("k0_latency", d0);

        // Count of zero finishes immediately
        start(4'd3, 16'd0);
        @(negedge iClock);
        chk("cnt0_done", 32'(oDone), 1);
        chk("cnt0_valid", 32'(oResidValid), 0);
        chk("cnt0_ready", 32'(oReady), 0);
        repeat (2) @(posedge iClock);
        #1;

        // Quotient overflow on the MAX_MSB=4 instance
        od0 = o_dones;
        start(4'd3, 16'd2);
        for (int i = 0; i < 4; i++) send(1'b0);
        @(negedge iClock);
        chk("ovf_err_at_limit", 32'(o_oError), 0);
        send(1'b0);
        @(negedge iClock);
        chk("ovf_err", 32'(o_oError), 1);
        chk("ovf_ready", 32'(o_oReady), 0);
        send(1'b0); send(1'b0);
        repeat (3) @(posedge iClock);
        #1;
        chk("ovf_sticky", 32'(o_oError), 1);
        chk("ovf_no_done", 32'(o_dones - od0), 0);
        d0 = dones;
        start(4'd3, 16'd1);
        push(16'hFFFC, 16'd0, 16'd7, 1'b1);
        @(negedge iClock);
        chk("ovf_cleared", 32'(o_oError), 0);
        send(1'b1); send(1'b1); send(1'b1); send(1'b1);
        drain("after_abort", d0);

        // Async reset mid-BINARY, then a clean partition
        start(4'd3, 16'd3);
        send(1'b0); send(1'b0); send(1'b0); send(1'b1); send(1'b1);
        #2;
        iReset = 1'b0;
        #1;
        chk("midrst_ready", 32'(oReady), 0);
        chk("midrst_valid", 32'(oResidValid), 0);
        chk("midrst_msb", 32'(oMSB), 0);
        chk("midrst_lsb", 32'(oLSB), 0);
        chk("midrst_residual", 32'(oResidual), 0);
        @(posedge iClock); #1;
        iReset = 1'b1;
        d0 = dones;
        start(4'd3, 16'd1);
        push(16'd11, 16'd2, 16'd6, 1'b1);
        send(1'b0); send(1'b0); send(1'b1); send(1'b1); send(1'b1); send(1'b0);
        drain("post_reset", d0);

`ifdef RICE_ESCAPE_EN
        // Escape with zero width: four zero residuals, never ready
        d0 = dones;
        start(4'd15, 16'd4);
        for (int e = 0; e < 4; e++) push(16'd0, 16'd0, 16'd0, e == 3);
        for (int i = 0; i < 5; i++) send(1'b0);
        for (int c = 0; c < 6; c++) begin
            @(negedge iClock);
            chk("zero_ready", 32'(oReady), 0);
        end
        drain("esc_zero", d0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
